// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector: Mealy match flag, overlap or
// non-overlap mode, input qualifier and a saturating match counter.
module seq_detector_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = 4,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(6),
  parameter logic [LEN_W-1:0]   DEF_LEN = LEN_W'(4),
  parameter logic               DEF_OVL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_valid,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               ovl_in,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed,
  output logic               len_err
);

  localparam logic [0:0]     ST_IDLE   = 1'b0;
  localparam logic [0:0]     ST_RUN    = 1'b1;
  localparam logic [LEN_W:0] MAX_LEN_X = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);

  logic [0:0]         r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [CNT_W-1:0]   r_count;
  logic               r_len_err;

  logic [MAX_LEN-1:0] w_cand;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_fill_ok;
  logic               w_len_ok;
  logic               w_match;
  logic               w_accept;

  // Only the low r_len bits take part in the compare; the mask zeroes the rest.
  assign w_cand    = {r_hist[MAX_LEN-2:0], x};
  assign w_mask    = ~({MAX_LEN{1'b1}} << r_len);
  assign w_fill_ok = ({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len};
  assign w_len_ok  = (len_in != '0) && ({1'b0, len_in} <= MAX_LEN_X);
  assign w_match   = (r_state == ST_RUN) && x_valid && w_fill_ok &&
                     (((w_cand ^ r_pat) & w_mask) == '0);
  assign w_accept  = (r_state == ST_RUN) && x_valid && !pat_load;

  assign z           = w_match && !pat_load && !rst;
  assign match_count = r_count;
  assign armed       = (r_state == ST_RUN);
  assign len_err     = r_len_err;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_pat     <= DEF_PAT;
      r_len     <= DEF_LEN;
      r_ovl     <= DEF_OVL;
      r_hist    <= '0;
      r_fill    <= '0;
      r_count   <= '0;
      r_len_err <= 1'b0;
    end else if (pat_load) begin
      r_pat     <= pat_in;
      r_len     <= len_in;
      r_ovl     <= ovl_in;
      r_hist    <= '0;
      r_fill    <= '0;
      r_count   <= '0;
      r_state   <= w_len_ok ? ST_RUN : ST_IDLE;
      r_len_err <= !w_len_ok;
    end else if (w_accept) begin
      r_hist <= w_cand;
      if (w_match && !r_ovl) begin
        r_fill <= '0;
      end else if (r_fill != MAX_FILL) begin
        r_fill <= r_fill + LEN_W'(1);
      end
      if (w_match && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Randomised and directed bench for seq_detector_prog against a bit-queue
// reference model; a second instance with a 2-bit counter covers saturation.
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0, x_valid = 1'b0, pat_load = 1'b0, ovl_in = 1'b0;
  logic [7:0] pat_in = '0;
  logic [3:0] len_in = '0;
  logic       z, armed, len_err, z2, armed2, len_err2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int n_vec = 0;
  int n_err = 0;

  seq_detector_prog dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pat_load(pat_load),
    .pat_in(pat_in), .len_in(len_in), .ovl_in(ovl_in),
    .z(z), .match_count(match_count), .armed(armed), .len_err(len_err)
  );

  seq_detector_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pat_load(pat_load),
    .pat_in(pat_in), .len_in(len_in), .ovl_in(ovl_in),
    .z(z2), .match_count(match_count2), .armed(armed2), .len_err(len_err2)
  );

  always #5 clk = ~clk;

  // Reference model: accepted bits in arrival order plus a count of bits
  // accepted since the last restart of detection.
  bit       m_armed, m_len_err, m_ovl;
  bit [7:0] m_pat;
  int       m_len, m_fresh, m_cnt8, m_cnt2;
  bit       seen[$];
  bit       g_zexp;
  logic     g_zobs;

  function automatic bit model_match(input bit xb);
    if (!m_armed || (m_fresh + 1 < m_len)) return 1'b0;
    if (m_pat[0] != xb) return 1'b0;
    for (int k = 1; k < m_len; k++)
      if (seen[seen.size() - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input bit xb, input bit xv, input bit pl,
                       input bit [7:0] pi, input bit [3:0] li, input bit oi,
                       input bit rs);
    bit mt;
    @(negedge clk);
    x = xb; x_valid = xv; pat_load = pl; pat_in = pi; len_in = li;
    ovl_in = oi; rst = rs;
    #1;
    mt     = xv && model_match(xb);
    g_zexp = mt && !pl && !rs;
    g_zobs = z;
    @(posedge clk);
    #1;
    if (rs) begin
      m_armed = 1; m_len_err = 0; m_pat = 8'b0110; m_len = 4; m_ovl = 1;
      seen.delete(); m_fresh = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (pl) begin
      m_pat = pi; m_len = li; m_ovl = oi;
      seen.delete(); m_fresh = 0; m_cnt8 = 0; m_cnt2 = 0;
      m_armed = (li >= 1) && (li <= 8);
      m_len_err = !m_armed;
    end else if (m_armed && xv) begin
      seen.push_back(xb);
      if (seen.size() > 16) void'(seen.pop_front());
      m_fresh = (mt && !m_ovl) ? 0 : m_fresh + 1;
      if (mt) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  task automatic send(input bit xb, input bit xv);
    drive(xb, xv, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input bit [7:0] pi, input bit [3:0] li, input bit oi);
    drive(1'b0, 1'b0, 1'b1, pi, li, oi, 1'b0);
  endtask

  task automatic do_rst();
    drive(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_rst();
    if (g_zobs !== 1'b0) begin
      n_err++; $display("FAIL reset_z: got %b want 0", g_zobs);
    end
    n_vec++;
    if ({armed, len_err, match_count} !== {1'b1, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_state: armed=%b len_err=%b cnt=%0d want 1 0 0",
               armed, len_err, match_count);
    end
    n_vec++;
  endtask

  task automatic test_stream(input string name, input bit [6:0] exp_z,
                             input int exp_cnt);
    bit stream[7] = '{0, 1, 1, 0, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      send(stream[i], 1'b1);
      if (g_zobs !== exp_z[6-i]) begin
        n_err++;
        $display("FAIL %s_z bit%0d: got %b want %b", name, i+1, g_zobs, exp_z[6-i]);
      end
      n_vec++;
    end
    if (match_count !== 8'(exp_cnt) || armed !== 1'b1) begin
      n_err++;
      $display("FAIL %s_cnt: got %0d armed=%b want %0d armed=1",
               name, match_count, armed, exp_cnt);
    end
    n_vec++;
  endtask

  task automatic test_gap();
    bit [7:0] bits = 8'b10110011;
    int       n_z = 0;
    bit       z_last = 0;
    load(8'b10110011, 4'd8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(bits[7-i], 1'b1);
      n_z += int'(g_zobs === 1'b1);
      if (i == 7) z_last = (g_zobs === 1'b1);
      if (i == 1 || i == 4) begin
        send(1'b1, 1'b0); n_z += int'(g_zobs === 1'b1);
        send(1'b0, 1'b0); n_z += int'(g_zobs === 1'b1);
      end
    end
    if (n_z != 1 || !z_last || match_count !== 8'd1) begin
      n_err++;
      $display("FAIL gap: z_count=%0d z_last=%b cnt=%0d want 1 1 1",
               n_z, z_last, match_count);
    end
    n_vec++;
  endtask

  task automatic test_saturate();
    bit [1:0] exp_c[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    load(8'h01, 4'd1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b1);
      if (g_zobs !== 1'b1 || match_count2 !== exp_c[i]) begin
        n_err++;
        $display("FAIL saturate bit%0d: z=%b cnt=%0d want z=1 cnt=%0d",
                 i+1, g_zobs, match_count2, exp_c[i]);
      end
      n_vec++;
    end
  endtask

  task automatic test_len_err();
    bit [3:0] bad[2] = '{4'd0, 4'd9};
    int       n_z;
    for (int b = 0; b < 2; b++) begin
      load(8'h00, bad[b], 1'b1);
      n_z = 0;
      for (int i = 0; i < 20; i++) begin
        send(1'($urandom_range(0, 1)), 1'b1);
        n_z += int'(g_zobs !== 1'b0);
      end
      if (len_err !== 1'b1 || armed !== 1'b0 || n_z != 0 || match_count !== 8'd0) begin
        n_err++;
        $display("FAIL len_err len=%0d: err=%b armed=%b z_hits=%0d want 1 0 0",
                 bad[b], len_err, armed, n_z);
      end
      n_vec++;
    end
    load(8'b0110, 4'd4, 1'b1);
    if (len_err !== 1'b0 || armed !== 1'b1) begin
      n_err++;
      $display("FAIL len_recover: err=%b armed=%b want 0 1", len_err, armed);
    end
    n_vec++;
  endtask

  task automatic test_load_and_rst_priority();
    do_rst();
    send(0, 1); send(1, 1); send(1, 1);
    drive(1'b0, 1'b1, 1'b1, 8'b0110, 4'd4, 1'b1, 1'b0);
    if (g_zobs !== 1'b0 || match_count !== 8'd0) begin
      n_err++;
      $display("FAIL load_drop: z=%b cnt=%0d want 0 0", g_zobs, match_count);
    end
    n_vec++;
    send(0, 1); send(1, 1); send(1, 1);
    do_rst();
    send(0, 1);
    if (g_zobs !== 1'b0) begin
      n_err++; $display("FAIL rst_midstream: got %b want 0", g_zobs);
    end
    n_vec++;
    send(0, 1); send(1, 1); send(1, 1); send(0, 1);
    if (g_zobs !== 1'b1 || match_count !== 8'd1) begin
      n_err++;
      $display("FAIL rst_refill: z=%b cnt=%0d want 1 1", g_zobs, match_count);
    end
    n_vec++;
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 2) do_rst();
      else if (r < 6)
        load(8'($urandom), 4'($urandom_range(0, 10) < 9 ? $urandom_range(1, 5)
                                                         : $urandom_range(0, 15)),
             1'($urandom_range(0, 1)));
      else send(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      if (g_zobs !== g_zexp) begin
        n_err++; $display("FAIL rand_z c%0d: got %b want %b", c, g_zobs, g_zexp);
      end
      n_vec++;
      if (match_count !== 8'(m_cnt8) || match_count2 !== 2'(m_cnt2)) begin
        n_err++;
        $display("FAIL rand_cnt c%0d: got %0d/%0d want %0d/%0d",
                 c, match_count, match_count2, m_cnt8, m_cnt2);
      end
      n_vec++;
      if (armed !== m_armed || len_err !== m_len_err) begin
        n_err++;
        $display("FAIL rand_flags c%0d: armed=%b err=%b want %b %b",
                 c, armed, len_err, m_armed, m_len_err);
      end
      n_vec++;
    end
  endtask

  initial begin
    test_reset();
    test_stream("ovl", 7'b0001001, 2);
    load(8'b0110, 4'd4, 1'b0);
    test_stream("novl", 7'b0001000, 1);
    test_gap();
    test_saturate();
    test_len_err();
    test_load_and_rst_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
